// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
// Turns per-stage stall requests into a 6-bit hold vector. A MEM-stage
// exception flushes the pipe and redirects the PC. After that, a short refill
// window ignores every request. A watchdog flags stalls that run too long.
// Optional macro STALL_PERF_EN adds a free-running stall-cycle counter.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned FLUSH_HOLD = 2,
    parameter int unsigned MAX_STALL  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;
    localparam logic [3:0]  HOLD_INIT = 4'(FLUSH_HOLD);
    localparam logic [15:0] WD_LIMIT  = 16'(MAX_STALL - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state, state_nxt;
    logic [3:0]  hold_cnt, hold_cnt_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [15:0] wd_cnt;

    // State, refill counter and latched redirect target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            pc_q     <= 32'h0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            pc_q     <= pc_nxt;
        end
    end

    // Next state and outputs; everything is forced quiet while reset is held
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        pc_nxt       = pc_q;
        stall        = 6'b000000;
        flush        = 1'b0;
        new_pc       = 32'h0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (excepttype != 32'h0) begin
                        // Exception beats any stall request in the same cycle
                        flush        = 1'b1;
                        new_pc       = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
                        state_nxt    = HOLD;
                        hold_cnt_nxt = HOLD_INIT;
                        pc_nxt       = new_pc;
                    end else if (stallreq_mem) begin
                        stall = 6'b011111;
                    end else if (stallreq_ex) begin
                        stall = 6'b001111;
                    end else if (stallreq_id) begin
                        stall = 6'b000111;
                    end else if (stallreq_if) begin
                        stall = 6'b000011;
                    end
                end
                HOLD: begin
                    // Refill window: inputs ignored, redirect target held
                    new_pc       = pc_q;
                    hold_cnt_nxt = hold_cnt - 4'd1;
                    if (hold_cnt <= 4'd1) begin
                        state_nxt    = IDLE;
                        hold_cnt_nxt = 4'd0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Watchdog: saturating run-length of consecutive stall cycles, sticky flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt        <= 16'd0;
            stall_timeout <= 1'b0;
        end else if (stall != 6'b000000) begin
            if (wd_cnt == WD_LIMIT)
                stall_timeout <= 1'b1;
            if (wd_cnt != 16'hFFFF)
                wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= 16'd0;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] perf_cnt;

    // Stall performance counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_cnt <= 32'h0;
        else if (stall != 6'b000000)
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign stall_cycles = perf_cnt;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed steps followed by random traffic,
// all compared against a cycle-count reference model kept in the bench.
module tb_pipe_ctrl;

    localparam int FLUSH_HOLD = 2;
    localparam int MAX_STALL  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic [31:0] excepttype = 32'h0, cp0_epc = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining refill cycles, latched target, stall run length
    int          m_hold;
    logic [31:0] m_pc;
    int          m_run;
    logic        m_tmo;
    logic [31:0] m_perf;

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_HOLD(FLUSH_HOLD), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype(excepttype), .cp0_epc(cp0_epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] perf_exp(input logic [31:0] n);
`ifdef STALL_PERF_EN
        return n;
`else
        return 32'h0;
`endif
    endfunction

    // One clock cycle: called at a negedge, drives inputs, checks, advances model
    task automatic step(input logic [3:0] req, input logic [31:0] exc, input logic [31:0] epc = 32'h0);
        logic [5:0]  es;
        logic        ef;
        logic [31:0] ep;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        excepttype = exc;
        cp0_epc    = epc;
        #1;
        es = 6'd0; ef = 1'b0; ep = 32'h0;
        if (m_hold > 0) begin
            ep = m_pc;
        end else if (exc != 32'h0) begin
            ef = 1'b1;
            ep = (exc == 32'he) ? epc : 32'h20;
        end else if (req[3]) es = 6'b011111;
        else if (req[2]) es = 6'b001111;
        else if (req[1]) es = 6'b000111;
        else if (req[0]) es = 6'b000011;
        chk("stall", 32'(stall), 32'(es));
        chk("flush", 32'(flush), 32'(ef));
        chk("new_pc", new_pc, ep);
        chk("stall_timeout", 32'(stall_timeout), 32'(m_tmo));
        chk("stall_cycles", stall_cycles, perf_exp(m_perf));
        if (m_hold > 0) m_hold--;
        else if (ef) begin m_hold = FLUSH_HOLD; m_pc = ep; end
        if (es != 6'd0) begin
            if (m_run >= MAX_STALL - 1) m_tmo = 1'b1;
            if (m_run < 65535) m_run++;
            m_perf++;
        end else m_run = 0;
        @(negedge clk);
    endtask

    // Reset asserted off the clock edge with busy inputs; released at a negedge
    task automatic do_reset();
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'hF;
        excepttype = 32'h8;
        #2 rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);
        chk("rst_cycles", stall_cycles, 32'h0);
        m_hold = 0; m_pc = 32'h0; m_run = 0; m_tmo = 1'b0; m_perf = 32'h0;
        @(posedge clk);
        @(negedge clk);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'h0;
        excepttype = 32'h0;
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] ex;
        @(negedge clk);
        do_reset();

        // ex + if requests: ex priority
        step(4'b0101, 32'h0);
        step(4'b0000, 32'h0);

        // exception with mem stall, then refill window, then stall resumes
        step(4'b1000, 32'h8);
        step(4'b1000, 32'h0);
        step(4'b1000, 32'h0);
        step(4'b1000, 32'h0);
        step(4'b0000, 32'h0);

        // ERET redirects to EPC
        step(4'b0000, 32'he, 32'hBFC0_0100);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);

        // second exception during refill is ignored until back in IDLE
        step(4'b0000, 32'h8);
        step(4'b0000, 32'he, 32'h1234_5678);
        step(4'b0000, 32'he, 32'h1234_5678);
        step(4'b0000, 32'he, 32'h1234_5678);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);

        // watchdog: 4 stalled edges set a sticky flag
        do_reset();
        repeat (4) step(4'b0010, 32'h0);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);
        chk("timeout_sticky", 32'(stall_timeout), 32'h1);
        do_reset();
        chk("timeout_cleared", 32'(stall_timeout), 32'h0);

        // perf counter: 10 stall cycles then 3 idle
        repeat (10) step(4'b0010, 32'h0);
        repeat (3) step(4'b0000, 32'h0);
        chk("perf_total", stall_cycles, perf_exp(32'd10));

        // reset in the middle of a refill window aborts it
        step(4'b0000, 32'h8);
        step(4'b0000, 32'h0);
        do_reset();
        step(4'b0100, 32'h8);
        step(4'b0000, 32'h0);
        step(4'b0000, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0: ex = 32'h8;
                1: ex = 32'he;
                2: ex = $urandom;
                default: ex = 32'h0;
            endcase
            if ($urandom_range(0, 60) == 0) do_reset();
            step(4'($urandom_range(0, 15)), ex, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
